// File: rtl/neurex_gemm_seq_pkg.sv
// Shared types for the GEMM job sequencer: FSM state encoding and drain-length helper.
package neurex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_WB,
    ST_FIN,
    ST_ERR
  } seq_state_e;

  // Cycles for the last operand beat to ripple through the skewed array.
  function automatic int drain_cyc(input int sys_row, input int sys_col);
    return sys_row + sys_col - 1;
  endfunction

endpackage

// File: rtl/neurex_gemm_seq_if.sv
// Job/control bus of the GEMM sequencer: job request, array beat strobes and tile writeback handshake.
interface neurex_gemm_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] num_in;
  logic [DATA_WIDTH-1:0] num_common;
  logic [DATA_WIDTH-1:0] num_out;
  logic [ADDR_WIDTH-1:0] base_in;
  logic [ADDR_WIDTH-1:0] base_w;
  logic [ADDR_WIDTH-1:0] base_out;
  logic                  array_ready;
  logic                  in_en;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;

  modport master (
    output start, abort, num_in, num_common, num_out, base_in, base_w, base_out,
    output array_ready, out_ready,
    input  in_en, w_en, in_addr, w_addr, acc_clr, out_valid, out_addr, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, num_in, num_common, num_out, base_in, base_w, base_out,
    input  array_ready, out_ready,
    output in_en, w_en, in_addr, w_addr, acc_clr, out_valid, out_addr, busy, done, cfg_err
  );
endinterface

// File: rtl/neurex_gemm_seq_nest_cnt.sv
// Three-level nested wrap counter (k innermost, then to, then ti) advanced by one inc pulse per beat.
module neurex_nest_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] k_max_i,
  input  logic [W-1:0] to_max_i,
  input  logic [W-1:0] ti_max_i,
  output logic         k_first_o,
  output logic         k_last_o,
  output logic         to_last_o,
  output logic         wrap_o
);
  logic [W-1:0] max_v [3];
  logic [2:0]   last;

  assign max_v[0] = k_max_i;
  assign max_v[1] = to_max_i;
  assign max_v[2] = ti_max_i;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_lvl
    logic [W-1:0] cnt_q;
    logic         step;

    // A level steps only when every inner level is at its limit.
    if (gi == 0) begin : g_base
      assign step = inc_i;
    end else begin : g_carry
      assign step = inc_i & (&last[gi-1:0]);
    end

    assign last[gi] = (cnt_q == max_v[gi]);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        cnt_q <= '0;
      else if (clr_i)   cnt_q <= '0;
      else if (step)    cnt_q <= last[gi] ? '0 : cnt_q + 1'b1;
    end
  end

  assign k_first_o = (g_lvl[0].cnt_q == '0);
  assign k_last_o  = last[0];
  assign to_last_o = last[1];
  assign wrap_o    = inc_i & (&last);
endmodule

// File: rtl/neurex_gemm_seq.sv
// GEMM job sequencer: walks output tiles of a systolic array, streams operand addresses, drains, hands off tiles.
module neurex_gemm_seq
  import neurex_pkg::*;
#(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rstn,
  neurex_gemm_seq_if.slave   bus
);
  localparam int DRAIN_CYC = drain_cyc(SYS_ROW, SYS_COL);
  localparam int DCW       = $clog2(DRAIN_CYC + 1);

  seq_state_e            state_q, state_d;
  logic                  accept, bad_cfg, beat;
  logic                  k_first, k_last, to_last, wrap;
  logic [DATA_WIDTH-1:0] k_max_q, to_max_q, ti_max_q;
  logic [ADDR_WIDTH-1:0] nc_step_q, base_w_q, in_row_q, w_row_q;
  logic [ADDR_WIDTH-1:0] in_addr_q, w_addr_q, out_addr_q;
  logic [ADDR_WIDTH-1:0] in_row_nx, w_row_nx;
  logic [DCW-1:0]        dcnt_q;
  logic                  job_last_q, wrap_to_q, cfg_err_q;

  assign bad_cfg = (bus.num_in == '0) || (bus.num_common == '0) || (bus.num_out == '0)
                || ((bus.num_in  % DATA_WIDTH'(SYS_ROW)) != '0)
                || ((bus.num_out % DATA_WIDTH'(SYS_COL)) != '0);
  assign accept  = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign beat    = (state_q == ST_STREAM) && bus.array_ready;

  neurex_nest_cnt #(.W(DATA_WIDTH)) u_nest (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (accept),
    .inc_i     (beat),
    .k_max_i   (k_max_q),
    .to_max_i  (to_max_q),
    .ti_max_i  (ti_max_q),
    .k_first_o (k_first),
    .k_last_o  (k_last),
    .to_last_o (to_last),
    .wrap_o    (wrap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = bad_cfg ? ST_ERR : ST_STREAM;
      ST_STREAM: if (beat && k_last) state_d = ST_DRAIN;
      ST_DRAIN:  if (dcnt_q == DCW'(DRAIN_CYC - 1)) state_d = ST_WB;
      ST_WB:     if (bus.out_ready) state_d = job_last_q ? ST_FIN : ST_STREAM;
      ST_FIN:    state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    bus.in_en     = beat;
    bus.w_en      = beat;
    bus.acc_clr   = beat && k_first;
    bus.out_valid = (state_q == ST_WB);
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = ((state_q == ST_FIN) || (state_q == ST_ERR)) && !bus.abort;
  end

  // Row bases for the next tile: a finished output-column sweep moves down one input tile row.
  assign in_row_nx = wrap_to_q ? in_row_q + nc_step_q : in_row_q;
  assign w_row_nx  = wrap_to_q ? base_w_q : w_row_q + nc_step_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_max_q    <= '0;
      to_max_q   <= '0;
      ti_max_q   <= '0;
      nc_step_q  <= '0;
      base_w_q   <= '0;
      in_row_q   <= '0;
      w_row_q    <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      out_addr_q <= '0;
      dcnt_q     <= '0;
      job_last_q <= 1'b0;
      wrap_to_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      dcnt_q <= (state_q == ST_DRAIN) ? dcnt_q + 1'b1 : '0;
      if (accept) begin
        cfg_err_q  <= bad_cfg;
        k_max_q    <= bus.num_common - DATA_WIDTH'(1);
        to_max_q   <= (bus.num_out / DATA_WIDTH'(SYS_COL)) - DATA_WIDTH'(1);
        ti_max_q   <= (bus.num_in / DATA_WIDTH'(SYS_ROW)) - DATA_WIDTH'(1);
        nc_step_q  <= ADDR_WIDTH'(bus.num_common);
        base_w_q   <= bus.base_w;
        in_row_q   <= bus.base_in;
        w_row_q    <= bus.base_w;
        in_addr_q  <= bus.base_in;
        w_addr_q   <= bus.base_w;
        out_addr_q <= bus.base_out;
        job_last_q <= 1'b0;
        wrap_to_q  <= 1'b0;
      end else if (beat) begin
        // The last k beat leaves addresses parked for the drain; tile position is remembered instead.
        if (k_last) begin
          job_last_q <= wrap;
          wrap_to_q  <= to_last;
        end else begin
          in_addr_q <= in_addr_q + 1'b1;
          w_addr_q  <= w_addr_q + 1'b1;
        end
      end else if ((state_q == ST_WB) && bus.out_ready && !job_last_q) begin
        in_row_q   <= in_row_nx;
        w_row_q    <= w_row_nx;
        in_addr_q  <= in_row_nx;
        w_addr_q   <= w_row_nx;
        out_addr_q <= out_addr_q + 1'b1;
      end
    end
  end

  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.out_addr = out_addr_q;
  assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_neurex_gemm_seq.sv
// Directed bench for neurex_gemm_seq on a 4x4 array: full jobs, stalls, bad config, reset and abort.
module tb_neurex_gemm_seq;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  neurex_gemm_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  neurex_gemm_seq #(
    .SYS_ROW(4), .SYS_COL(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observations gathered every cycle.
  int   beats = 0, clrs = 0, dones = 0, ov_cyc = 0, addr_bad = 0, gap = 0;
  logic ov_prev = 1'b0;
  int   oaddr_q[$];
  int   gap_q[$];

  // Geometry of the job currently running, for the per-beat address model.
  int            beat_base = 0, job_nc = 1, job_tpr = 1;
  logic [AW-1:0] job_bin = '0, job_bw = '0;

  // Snapshots taken before each job.
  int b0, c0, d0, o0, a0, q0, g0;

  always @(negedge clk) begin
    int            n, k, tile;
    logic [AW-1:0] ein, ew;
    if (bus.in_en === 1'b1) begin
      n    = beats - beat_base;
      k    = n % job_nc;
      tile = n / job_nc;
      ein  = job_bin + AW'((tile / job_tpr) * job_nc + k);
      ew   = job_bw  + AW'((tile % job_tpr) * job_nc + k);
      if (bus.in_addr !== ein || bus.w_addr !== ew || bus.w_en !== 1'b1 || bus.acc_clr !== (k == 0))
        addr_bad <= addr_bad + 1;
      beats <= beats + 1;
      gap   <= 0;
    end else begin
      if (bus.out_valid === 1'b1 && !ov_prev) gap_q.push_back(gap);
      gap <= gap + 1;
    end
    if (bus.acc_clr === 1'b1) clrs <= clrs + 1;
    if (bus.done === 1'b1) dones <= dones + 1;
    if (bus.out_valid === 1'b1) ov_cyc <= ov_cyc + 1;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) oaddr_q.push_back(int'(bus.out_addr));
    ov_prev <= (bus.out_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic snap();
    b0 = beats; c0 = clrs; d0 = dones; o0 = ov_cyc; a0 = addr_bad;
    q0 = oaddr_q.size(); g0 = gap_q.size();
  endtask

  task automatic start_job(input int ni, input int nc, input int no,
                           input logic [AW-1:0] bi, input logic [AW-1:0] bw, input logic [AW-1:0] bo);
    @(negedge clk);
    bus.num_in = DW'(ni); bus.num_common = DW'(nc); bus.num_out = DW'(no);
    bus.base_in = bi; bus.base_w = bw; bus.base_out = bo;
    bus.start = 1'b1;
    beat_base = beats; job_nc = (nc == 0) ? 1 : nc; job_tpr = (no / 4 == 0) ? 1 : no / 4;
    job_bin = bi; job_bw = bw;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int c = 0;
    while (bus.busy === 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_full_job(input string tag);
    chk({tag, "_beats"}, beats - b0, 64);
    chk({tag, "_addr_model"}, addr_bad - a0, 0);
    chk({tag, "_tiles"}, oaddr_q.size() - q0, 8);
    chk({tag, "_done"}, dones - d0, 1);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.num_in = '0; bus.num_common = '0; bus.num_out = '0;
    bus.base_in = '0; bus.base_w = '0; bus.base_out = '0;
    bus.array_ready = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_ctl", {25'd0, bus.busy, bus.in_en, bus.w_en, bus.acc_clr, bus.out_valid, bus.done, bus.cfg_err}, 32'd0);
    chk("rst_addr", {bus.in_addr, bus.w_addr}, 32'd0);
    chk("rst_out_addr", {16'd0, bus.out_addr}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Plain 8x8 * 8x16 job, always ready.
    snap();
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    chk("t1_first_beat", {30'd0, bus.in_en, bus.acc_clr}, 32'd3);
    chk("t1_first_in_addr", {16'd0, bus.in_addr}, 32'h100);
    chk("t1_first_w_addr", {16'd0, bus.w_addr}, 32'h200);
    wait_idle("t1_timeout", 400);
    check_full_job("t1");
    chk("t1_acc_clr", clrs - c0, 8);
    chk("t1_ov_cycles", ov_cyc - o0, 8);
    if (oaddr_q.size() >= q0 + 8)
      for (int i = 0; i < 8; i++) chk("t1_out_addr", oaddr_q[q0 + i], i);
    if (gap_q.size() >= g0 + 8)
      for (int i = 0; i < 8; i++) chk("t1_drain_gap", gap_q[g0 + i], 7);

    // Array stall for 3 cycles at tile 0, k=3.
    snap();
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    repeat (3) @(negedge clk);
    bus.array_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_en", {31'd0, bus.in_en}, 32'd0);
      chk("t2_stall_addr", {16'd0, bus.in_addr}, 32'h103);
      @(negedge clk);
    end
    bus.array_ready = 1'b1;
    wait_idle("t2_timeout", 400);
    check_full_job("t2");

    // Writeback back-pressure for 5 cycles on tile 2.
    snap();
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    for (int c = 0; c < 200 && (oaddr_q.size() - q0) < 2; c++) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 100 && bus.out_valid !== 1'b1; c++) @(negedge clk);
    chk("t3_wb_seen", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_addr", {16'd0, bus.out_addr}, 32'd2);
      chk("t3_hold_no_en", {31'd0, bus.in_en}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_idle("t3_timeout", 400);
    check_full_job("t3");
    chk("t3_ov_cycles", ov_cyc - o0, 13);
    if (oaddr_q.size() >= q0 + 3) chk("t3_tile2_addr", oaddr_q[q0 + 2], 2);

    // Bad config (num_in not a multiple of 4), then a valid job clears cfg_err.
    snap();
    start_job(6, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    chk("t4_err_cycle1", {28'd0, bus.done, bus.cfg_err, bus.busy, bus.in_en}, 32'b1110);
    @(negedge clk);
    chk("t4_err_cycle2", {29'd0, bus.done, bus.cfg_err, bus.busy}, 32'b010);
    chk("t4_err_beats", beats - b0, 0);
    chk("t4_err_done", dones - d0, 1);
    snap();
    start_job(4, 2, 4, 16'h0040, 16'h0050, 16'h0060);
    chk("t4_clear", {29'd0, bus.cfg_err, bus.in_en, bus.acc_clr}, 32'b011);
    chk("t4_ok_in_addr", {16'd0, bus.in_addr}, 32'h40);
    wait_idle("t4_timeout", 100);
    chk("t4_ok_beats", beats - b0, 2);
    chk("t4_ok_done", dones - d0, 1);
    if (oaddr_q.size() >= q0 + 1) chk("t4_ok_out_addr", oaddr_q[q0], 32'h60);

    // Asynchronous reset in the middle of streaming.
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_ctl", {25'd0, bus.busy, bus.in_en, bus.w_en, bus.acc_clr, bus.out_valid, bus.done, bus.cfg_err}, 32'd0);
    chk("t5_rst_addr", {bus.in_addr, bus.w_addr}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    snap();
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    wait_idle("t5_timeout", 400);
    check_full_job("t5");

    // Ignored start while busy, then abort during drain.
    snap();
    start_job(8, 8, 16, 16'h0100, 16'h0200, 16'h0000);
    @(negedge clk);
    bus.num_in = 16'd4; bus.num_common = 16'd2; bus.num_out = 16'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_in_drain", {29'd0, bus.busy, bus.in_en, bus.out_valid}, 32'b100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t6_abort_idle", {30'd0, bus.busy, bus.out_valid}, 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_beats", beats - b0, 8);
    chk("t6_no_done", dones - d0, 0);
    chk("t6_no_tiles", oaddr_q.size() - q0, 0);
    chk("t6_addr_model", addr_bad - a0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
